fv_ccp_tagpipe_gen_addr: RTL and testbench
==========================================

# fv_ccp_tagpipe_gen_addr

Reconstructs a full cache-line address from the tag-pipe coordinates `{bank, set, tag}` of a CCP tag array entry. It is the inverse of the tag-pipe index generator. It sits in the DV/FV side of the CCP tagpipe, where eviction and writeback tag reads are converted back into system addresses for scoreboards and formal checkers. The block is a 2-stage valid/ready pipeline with bank-range checking and a completed-transaction counter.

## Interface
Parameters:
- N_SETS, 1024, total sets across all tag banks (power of 2)
- N_TAG_BANKS, 2, number of tag banks (1, 2 or 4)
- BNK_W, $clog2(N_TAG_BANKS), bank-select bit count (0 when N_TAG_BANKS=1)
- SET_PER_BANK_W, $clog2(N_SETS/N_TAG_BANKS), per-bank set index width
- ADDRESS_W, 32, system address width
- CACHE_LINE_OFFSET_W, 6, line offset width
- TAG_W, ADDRESS_W-(BNK_W+SET_PER_BANK_W+CACHE_LINE_OFFSET_W), tag width
- BANK_SEL_BIT, 0, lowest position of the bank-select bits within the full set index (0..SET_PER_BANK_W)
- MAX_TAG_BANKS_W, 2, width of the bank number port
- CNT_W, 16, transaction counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- bnk_num  in  MAX_TAG_BANKS_W  tag bank number
- set  in  SET_PER_BANK_W  per-bank set index
- tag  in  TAG_W  tag bits
- out_valid  out  1  reconstructed address valid
- out_ready  in  1  consumer ready
- address_out  out  ADDRESS_W  reconstructed line address
- out_err  out  1  this output beat had an out-of-range bank
- err_bad_bank  out  1  sticky: any accepted request had bnk_num >= N_TAG_BANKS
- txn_cnt  out  CNT_W  count of completed output handshakes

## Operation
- Full index construction (width SET_PER_BANK_W+BNK_W): `set` bits fill positions below BANK_SEL_BIT. The BNK_W low bits of `bnk_num` occupy [BANK_SEL_BIT+BNK_W-1:BANK_SEL_BIT]. The remaining `set` bits fill positions above. When N_TAG_BANKS=1, the index equals `set` and `bnk_num` is ignored for address formation.
- address_out = {tag, full_index, CACHE_LINE_OFFSET_W'b0}. Offset bits are always zero.
- Stage 1 (S1) registers the inputs and computes the range check: err = (bnk_num >= N_TAG_BANKS). Stage 2 (S2) registers address_out and out_err.
- An out-of-range bank is not dropped. The beat passes through with truncated bank bits, out_err=1, and err_bad_bank set.
- err_bad_bank is set on the S1 load of a bad request and clears only on reset.
- txn_cnt increments on each out_valid&out_ready and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (async assert, sync-released use): S1/S2 valid=0, out_valid=0, address_out=0, out_err=0, err_bad_bank=0, txn_cnt=0. in_ready=1 in the first cycle after reset release.
- Latency is 2 cycles. A request accepted at edge N presents out_valid at N+2 if S2 is free.
- Throughput is 1 beat/cycle when out_ready is held at 1.
- S2 loads from S1 when !s2_valid || out_ready.
- in_ready = !s1_valid || S2-load-condition (bubbles collapse). in_ready has no combinational path from in_valid.
- out_valid, address_out and out_err are held stable while out_valid && !out_ready.
- When both stages are full and out_ready=0, in_ready=0. When out_ready rises, both stages advance in the same cycle.
- Simultaneous S1 load and S1→S2 move in one cycle is legal. No beat is lost or duplicated.
- Reset asserted mid-operation discards all in-flight beats immediately. The counter and sticky flag clear.

## Test plan
- Default parameters, BANK_SEL_BIT=0, tag=0x1234, set=0x0AB, bnk_num=1, out_ready=1 → address_out=0x123455C0, out_err=0, appears 2 cycles after accept, txn_cnt=1.
- BANK_SEL_BIT=9, same inputs → address_out=0x1234AAC0.
- bnk_num=2 with N_TAG_BANKS=2, tag=0, set=0 → out_err=1 on that beat only, err_bad_bank=1 and stays 1 across 10 subsequent good beats.
- Stream 8 back-to-back requests with out_ready=0 for cycles 3–7 → in_ready falls after 2 beats are held, output stays stable, all 8 addresses emerge in order, txn_cnt=8.
- CNT_W=4, complete 17 beats → txn_cnt reads 15, then 0, then 1.
- Assert reset_n=0 with both stages full → out_valid=0 and in_ready=1 in the first cycle after release, txn_cnt=0, err_bad_bank=0.

Source files
------------

// File: rtl/fv_ccp_tagpipe_gen_addr_if.sv
// Request/response bundle for the tag-pipe address regenerator.
// The DUT takes the slave side; a driver or bench takes the master side.
interface fv_ccp_tagpipe_gen_addr_if #(
    parameter int MAX_TAG_BANKS_W = 2,
    parameter int SET_PER_BANK_W  = 9,
    parameter int TAG_W           = 16,
    parameter int ADDRESS_W       = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic [MAX_TAG_BANKS_W-1:0] bnk_num;
    logic [SET_PER_BANK_W-1:0]  set;
    logic [TAG_W-1:0]           tag;
    logic                       out_valid;
    logic                       out_ready;
    logic [ADDRESS_W-1:0]       address_out;
    logic                       out_err;

    modport master (
        output in_valid, bnk_num, set, tag, out_ready,
        input  in_ready, out_valid, address_out, out_err
    );

    modport slave (
        input  in_valid, bnk_num, set, tag, out_ready,
        output in_ready, out_valid, address_out, out_err
    );
endinterface

// File: rtl/fv_ccp_tagpipe_gen_addr.sv
// Rebuilds a cache-line address from tag-pipe {bank, set, tag} coordinates through a
// 2-stage valid/ready pipeline, flagging out-of-range banks and counting completed beats.
module fv_ccp_tagpipe_gen_addr #(
    parameter int N_SETS              = 1024,
    parameter int N_TAG_BANKS         = 2,
    parameter int BNK_W               = $clog2(N_TAG_BANKS),
    parameter int SET_PER_BANK_W      = $clog2(N_SETS / N_TAG_BANKS),
    parameter int ADDRESS_W           = 32,
    parameter int CACHE_LINE_OFFSET_W = 6,
    parameter int TAG_W               = ADDRESS_W - (BNK_W + SET_PER_BANK_W + CACHE_LINE_OFFSET_W),
    parameter int BANK_SEL_BIT        = 0,
    parameter int MAX_TAG_BANKS_W     = 2,
    parameter int CNT_W               = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    fv_ccp_tagpipe_gen_addr_if.slave     bus,
    output logic                         err_bad_bank,
    output logic [CNT_W-1:0]             txn_cnt
);
    localparam int IDX_W = SET_PER_BANK_W + BNK_W;
    localparam logic [IDX_W-1:0] LOW_MASK = (IDX_W'(1) << BANK_SEL_BIT) - IDX_W'(1);
    localparam logic [IDX_W-1:0] BNK_MASK = (IDX_W'(1) << BNK_W) - IDX_W'(1);
    localparam logic [MAX_TAG_BANKS_W:0] BANK_LIMIT = (MAX_TAG_BANKS_W + 1)'(N_TAG_BANKS);

    logic [IDX_W-1:0]     set_ext;
    logic [IDX_W-1:0]     bnk_ext;
    logic [IDX_W-1:0]     full_idx;
    logic [ADDRESS_W-1:0] req_addr;
    logic                 req_err;

    logic                 s1_valid;
    logic [ADDRESS_W-1:0] s1_addr;
    logic                 s1_err;
    logic                 s2_valid;
    logic [ADDRESS_W-1:0] s2_addr;
    logic                 s2_err;
    logic                 s2_load;
    logic                 accept;

    // Set bits split around the bank field; a zero-width bank field masks bnk_num out entirely.
    always_comb begin
        set_ext  = IDX_W'(bus.set);
        bnk_ext  = IDX_W'(bus.bnk_num) & BNK_MASK;
        full_idx = (set_ext & LOW_MASK)
                 | (bnk_ext << BANK_SEL_BIT)
                 | ((set_ext >> BANK_SEL_BIT) << (BANK_SEL_BIT + BNK_W));
        req_addr = {bus.tag, full_idx, {CACHE_LINE_OFFSET_W{1'b0}}};
        req_err  = ({1'b0, bus.bnk_num} >= BANK_LIMIT);
    end

    assign s2_load         = !s2_valid || bus.out_ready;
    assign bus.in_ready    = !s1_valid || s2_load;
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.out_valid   = s2_valid;
    assign bus.address_out = s2_addr;
    assign bus.out_err     = s2_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid     <= 1'b0;
            s1_addr      <= '0;
            s1_err       <= 1'b0;
            s2_valid     <= 1'b0;
            s2_addr      <= '0;
            s2_err       <= 1'b0;
            err_bad_bank <= 1'b0;
            txn_cnt      <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_addr  <= req_addr;
                s1_err   <= req_err;
                if (req_err) begin
                    err_bad_bank <= 1'b1;
                end
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_addr <= s1_addr;
                    s2_err  <= s1_err;
                end
            end

            if (s2_valid && bus.out_ready) begin
                txn_cnt <= txn_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fv_ccp_tagpipe_gen_addr.sv
// Directed bench: three instances (bank field at bit 0, bank field at bit 9, 4-bit counter)
// share one stimulus stream and are checked against hand-computed addresses.
module tb_fv_ccp_tagpipe_gen_addr;
    typedef struct {
        logic [15:0] tag;
        logic [8:0]  set;
        logic [1:0]  bnk;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        err;
    } vec_t;

    logic clk;
    logic reset_n;
    logic        err_a, err_b, err_c;
    logic [15:0] txn_a, txn_b;
    logic [3:0]  txn_c;

    int n_chk;
    int n_bad;
    vec_t vec[12];
    int stim_q[$];

    fv_ccp_tagpipe_gen_addr_if #(.MAX_TAG_BANKS_W(2), .SET_PER_BANK_W(9), .TAG_W(16), .ADDRESS_W(32)) ifa();
    fv_ccp_tagpipe_gen_addr_if #(.MAX_TAG_BANKS_W(2), .SET_PER_BANK_W(9), .TAG_W(16), .ADDRESS_W(32)) ifb();
    fv_ccp_tagpipe_gen_addr_if #(.MAX_TAG_BANKS_W(2), .SET_PER_BANK_W(9), .TAG_W(16), .ADDRESS_W(32)) ifc();

    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.bnk_num   = ifa.bnk_num;
    assign ifb.set       = ifa.set;
    assign ifb.tag       = ifa.tag;
    assign ifb.out_ready = ifa.out_ready;
    assign ifc.in_valid  = ifa.in_valid;
    assign ifc.bnk_num   = ifa.bnk_num;
    assign ifc.set       = ifa.set;
    assign ifc.tag       = ifa.tag;
    assign ifc.out_ready = ifa.out_ready;

    fv_ccp_tagpipe_gen_addr #(.BANK_SEL_BIT(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave), .err_bad_bank(err_a), .txn_cnt(txn_a));
    fv_ccp_tagpipe_gen_addr #(.BANK_SEL_BIT(9)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave), .err_bad_bank(err_b), .txn_cnt(txn_b));
    fv_ccp_tagpipe_gen_addr #(.CNT_W(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(ifc.slave), .err_bad_bank(err_c), .txn_cnt(txn_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n       = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Drives stim_q in order, scoreboards every output handshake and checks the
    // output holds steady while stalled.
    task automatic run_stream(input int stall_lo, input int stall_hi, output int cycles, output int stalls);
        int in_i, out_i, cyc;
        logic held;
        logic [31:0] held_a;
        vec_t v;
        in_i = 0; out_i = 0; cyc = 0; held = 1'b0; held_a = '0; stalls = 0;
        while (out_i < stim_q.size() && cyc < 200) begin
            ifa.out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            if (in_i < stim_q.size()) begin
                v = vec[stim_q[in_i]];
                ifa.in_valid = 1'b1;
                ifa.tag      = v.tag;
                ifa.set      = v.set;
                ifa.bnk_num  = v.bnk;
            end else begin
                ifa.in_valid = 1'b0;
            end
            #1;
            if (held) begin
                check("hold_valid", ifa.out_valid, 1);
                check("hold_addr", ifa.address_out, held_a);
            end
            if (ifa.in_valid && !ifa.in_ready) stalls++;
            if (ifa.in_valid && ifa.in_ready) in_i++;
            if (ifa.out_valid && ifa.out_ready) begin
                v = vec[stim_q[out_i]];
                check("addr_sel0", ifa.address_out, v.exp_a);
                check("addr_sel9", ifb.address_out, v.exp_b);
                check("addr_cnt4", ifc.address_out, v.exp_a);
                check("out_err", ifa.out_err, v.err);
                out_i++;
            end
            held   = ifa.out_valid && !ifa.out_ready;
            held_a = ifa.address_out;
            @(posedge clk); #1;
            cyc++;
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        if (out_i != stim_q.size()) check("stream_timeout", out_i, stim_q.size());
        cycles = cyc;
    endtask

    initial begin
        int cyc, st;
        n_chk = 0; n_bad = 0;
        reset_n = 1'b0;
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        ifa.tag = '0; ifa.set = '0; ifa.bnk_num = '0;

        vec[0]  = '{16'h1234, 9'h0AB, 2'd1, 32'h123455C0, 32'h1234AAC0, 1'b0};
        vec[1]  = '{16'hFFFF, 9'h1FF, 2'd1, 32'hFFFFFFC0, 32'hFFFFFFC0, 1'b0};
        vec[2]  = '{16'h0000, 9'h000, 2'd0, 32'h00000000, 32'h00000000, 1'b0};
        vec[3]  = '{16'hABCD, 9'h100, 2'd0, 32'hABCD8000, 32'hABCD4000, 1'b0};
        vec[4]  = '{16'h0001, 9'h001, 2'd0, 32'h00010080, 32'h00010040, 1'b0};
        vec[5]  = '{16'h8000, 9'h000, 2'd1, 32'h80000040, 32'h80008000, 1'b0};
        vec[6]  = '{16'h5A5A, 9'h155, 2'd0, 32'h5A5AAA80, 32'h5A5A5540, 1'b0};
        vec[7]  = '{16'h0F0F, 9'h0AA, 2'd1, 32'h0F0F5540, 32'h0F0FAA80, 1'b0};
        vec[8]  = '{16'h7777, 9'h003, 2'd1, 32'h777701C0, 32'h777780C0, 1'b0};
        vec[9]  = '{16'h0100, 9'h080, 2'd0, 32'h01004000, 32'h01002000, 1'b0};
        vec[10] = '{16'h0000, 9'h000, 2'd2, 32'h00000000, 32'h00000000, 1'b1};
        vec[11] = '{16'h0002, 9'h004, 2'd3, 32'h00020240, 32'h00028100, 1'b1};

        // reset state
        do_reset();
        #1;
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_in_ready", ifa.in_ready, 1);
        check("rst_addr", ifa.address_out, 0);
        check("rst_out_err", ifa.out_err, 0);
        check("rst_err_flag", err_a, 0);
        check("rst_txn", txn_a, 0);

        // single beat, latency
        stim_q = '{0};
        run_stream(-1, -1, cyc, st);
        check("single_cycles", cyc, 3);
        check("single_txn", txn_a, 1);
        check("single_err_flag", err_a, 0);

        // bad bank then 10 good beats
        do_reset();
        stim_q = '{10, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_stream(-1, -1, cyc, st);
        check("badbank_cycles", cyc, 13);
        check("badbank_stalls", st, 0);
        check("badbank_txn", txn_a, 11);
        check("badbank_flag_a", err_a, 1);
        check("badbank_flag_b", err_b, 1);

        // back-pressure: consumer stalls cycles 3..7
        do_reset();
        stim_q = '{2, 3, 4, 5, 6, 7, 8, 9};
        run_stream(3, 7, cyc, st);
        check("bp_cycles", cyc, 15);
        check("bp_stalls", st, 5);
        check("bp_txn", txn_a, 8);
        check("bp_err_flag", err_a, 0);

        // counter wrap on the 4-bit instance
        do_reset();
        stim_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 0, 1, 2, 3};
        run_stream(-1, -1, cyc, st);
        check("wrap_txn_a15", txn_a, 15);
        check("wrap_txn_c15", txn_c, 15);
        check("wrap_flag_c", err_c, 1);
        stim_q = '{4};
        run_stream(-1, -1, cyc, st);
        check("wrap_txn_a16", txn_a, 16);
        check("wrap_txn_c0", txn_c, 0);
        stim_q = '{5};
        run_stream(-1, -1, cyc, st);
        check("wrap_txn_a17", txn_a, 17);
        check("wrap_txn_c1", txn_c, 1);

        // reset with both stages full
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.tag = vec[10].tag; ifa.set = vec[10].set; ifa.bnk_num = vec[10].bnk;
        @(posedge clk); #1;
        ifa.tag = vec[0].tag; ifa.set = vec[0].set; ifa.bnk_num = vec[0].bnk;
        @(posedge clk); #1;
        check("full_in_ready", ifa.in_ready, 0);
        check("full_out_valid", ifa.out_valid, 1);
        check("full_out_err", ifa.out_err, 1);
        check("full_err_flag", err_a, 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_out_valid", ifa.out_valid, 0);
        check("async_txn", txn_a, 0);
        check("async_err_flag", err_a, 0);
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        check("rel_out_valid", ifa.out_valid, 0);
        check("rel_in_ready", ifa.in_ready, 1);
        check("rel_txn", txn_a, 0);
        check("rel_err_flag", err_a, 0);
        @(posedge clk); #1;
        check("rel_no_ghost", ifa.out_valid, 0);
        check("rel_txn_hold", txn_a, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
